cdb_arbiter: RTL and testbench

- Registered completion arbiter for the EX stage.
- Collects finished results from up to NUM_REQ producers: ALU1, ALU2, MULT1, MULT2 and MEM.
- Each producer gets a 1-entry holding register. Each cycle, up to NUM_BUS held results are granted onto the common data buses, using a round-robin pointer.
- Back-pressure is returned per producer through req_ready; the producer stalls its pipeline when req_ready is low.

---
 rtl/cdb_pkg.sv | 19 +
 rtl/cdb_rr_picker.sv | 44 ++++
 rtl/cdb_arbiter.sv | 141 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_pkg.sv
// Shared widths, producer indices and helpers for the CDB completion arbiter.
package cdb_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 3;

    localparam int REQ_ALU1  = 0;
    localparam int REQ_ALU2  = 1;
    localparam int REQ_MULT1 = 2;
    localparam int REQ_MULT2 = 3;
    localparam int REQ_MEM   = 4;

    // Valid only for v < 2*n, which holds for pointer + offset in the scan.
    function automatic int wrap_idx(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational round-robin picker: grants up to NUM_BUS held slots, scanning from rr_ptr.
module cdb_rr_picker
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int NUM_BUS = 2
) (
    input  logic [NUM_REQ-1:0]       i_hold_valid,
    input  logic [IDX_W-1:0]         i_rr_ptr,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic [NUM_BUS-1:0]       o_lane_valid,
    output logic [NUM_BUS*IDX_W-1:0] o_lane_idx,
    output logic [IDX_W-1:0]         o_next_ptr
);

    always_comb begin
        int n_granted;
        int idx;
        o_grant      = '0;
        o_lane_valid = '0;
        o_lane_idx   = '0;
        o_next_ptr   = i_rr_ptr;
        n_granted    = 0;
        idx          = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = wrap_idx(int'(i_rr_ptr) + k, NUM_REQ);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (i == idx && i_hold_valid[i] && n_granted < NUM_BUS) begin
                    o_grant[i] = 1'b1;
                    // Scan order decides the lane: first hit on lane 0, next on lane 1.
                    for (int b = 0; b < NUM_BUS; b++) begin
                        if (b == n_granted) begin
                            o_lane_valid[b]                = 1'b1;
                            o_lane_idx[b*IDX_W +: IDX_W]   = IDX_W'(i);
                        end
                    end
                    o_next_ptr = IDX_W'(wrap_idx(i + 1, NUM_REQ));
                    n_granted  = n_granted + 1;
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Registered completion arbiter: 1-entry hold per producer, NUM_BUS CDB lanes per cycle.
// Define CDB_STALL_CNT_EN to build the saturating stall counter behind o_stall_count.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 5,
    parameter int NUM_BUS = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_squash,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    i_req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_value,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic [NUM_BUS-1:0]          o_cdb_valid,
    output logic [NUM_BUS*TAG_W-1:0]    o_cdb_tag,
    output logic [NUM_BUS*DATA_W-1:0]   o_cdb_value,
    output logic [NUM_BUS*IDX_W-1:0]    o_cdb_src,
    output logic [31:0]                 o_stall_count
);

    logic [NUM_REQ-1:0]          r_hold_valid;
    logic [TAG_W-1:0]            r_hold_tag   [NUM_REQ];
    logic [DATA_W-1:0]           r_hold_value [NUM_REQ];
    logic [IDX_W-1:0]            r_rr_ptr;
    logic [NUM_BUS-1:0]          r_cdb_valid;
    logic [NUM_BUS*TAG_W-1:0]    r_cdb_tag;
    logic [NUM_BUS*DATA_W-1:0]   r_cdb_value;
    logic [NUM_BUS*IDX_W-1:0]    r_cdb_src;

    logic [NUM_REQ-1:0]          w_grant;
    logic [NUM_BUS-1:0]          w_lane_valid;
    logic [NUM_BUS*IDX_W-1:0]    w_lane_idx;
    logic [IDX_W-1:0]            w_next_ptr;
    logic [NUM_REQ-1:0]          w_accept;
    logic [NUM_REQ-1:0]          w_hold_valid_nxt;
    logic [NUM_BUS-1:0]          w_cdb_valid_nxt;
    logic [NUM_BUS*TAG_W-1:0]    w_cdb_tag_nxt;
    logic [NUM_BUS*DATA_W-1:0]   w_cdb_value_nxt;
    logic [NUM_BUS*IDX_W-1:0]    w_cdb_src_nxt;

    cdb_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .NUM_BUS (NUM_BUS)
    ) u_picker (
        .i_hold_valid (r_hold_valid),
        .i_rr_ptr     (r_rr_ptr),
        .o_grant      (w_grant),
        .o_lane_valid (w_lane_valid),
        .o_lane_idx   (w_lane_idx),
        .o_next_ptr   (w_next_ptr)
    );

    // Ready depends only on registered state, never on i_req_valid.
    assign o_req_ready = ~r_hold_valid | w_grant;
    assign w_accept    = i_req_valid & o_req_ready;

    always_comb begin
        w_hold_valid_nxt = '0;
        if (!i_squash) begin
            w_hold_valid_nxt = (r_hold_valid & ~w_grant) | w_accept;
        end
    end

    always_comb begin
        w_cdb_valid_nxt = w_lane_valid;
        w_cdb_src_nxt   = w_lane_idx;
        w_cdb_tag_nxt   = '0;
        w_cdb_value_nxt = '0;
        for (int b = 0; b < NUM_BUS; b++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_lane_valid[b] && w_lane_idx[b*IDX_W +: IDX_W] == IDX_W'(i)) begin
                    w_cdb_tag_nxt[b*TAG_W +: TAG_W]    = r_hold_tag[i];
                    w_cdb_value_nxt[b*DATA_W +: DATA_W] = r_hold_value[i];
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_hold_valid <= '0;
            r_rr_ptr     <= '0;
            r_cdb_valid  <= '0;
            r_cdb_tag    <= '0;
            r_cdb_value  <= '0;
            r_cdb_src    <= '0;
        end else begin
            r_hold_valid <= w_hold_valid_nxt;
            if (i_squash) begin
                // Flush drops in-flight lanes but keeps the fairness pointer.
                r_cdb_valid <= '0;
                r_cdb_tag   <= '0;
                r_cdb_value <= '0;
                r_cdb_src   <= '0;
            end else begin
                r_cdb_valid <= w_cdb_valid_nxt;
                r_cdb_tag   <= w_cdb_tag_nxt;
                r_cdb_value <= w_cdb_value_nxt;
                r_cdb_src   <= w_cdb_src_nxt;
                r_rr_ptr    <= w_next_ptr;
            end
        end
    end

    // Payload needs no reset; hold_valid qualifies it.
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_hold_tag[i]   <= i_req_tag[i*TAG_W +: TAG_W];
                r_hold_value[i] <= i_req_value[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_cdb_valid = r_cdb_valid;
    assign o_cdb_tag   = r_cdb_tag;
    assign o_cdb_value = r_cdb_value;
    assign o_cdb_src   = r_cdb_src;

`ifdef CDB_STALL_CNT_EN
    logic [31:0] r_stall_count;
    logic        w_stall;

    assign w_stall = |(r_hold_valid & ~w_grant);

    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_stall_count <= '0;
        end else if (w_stall && r_stall_count != 32'hFFFF_FFFF) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized bench for cdb_arbiter against a queue-based model, plus directed scenarios.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_REQ = 5;
    localparam int NUM_BUS = 2;

    logic                        clk = 1'b0;
    logic                        rst_n;
    logic                        squash;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ*TAG_W-1:0]    req_tag;
    logic [NUM_REQ*DATA_W-1:0]   req_value;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_BUS-1:0]          cdb_valid;
    logic [NUM_BUS*TAG_W-1:0]    cdb_tag;
    logic [NUM_BUS*DATA_W-1:0]   cdb_value;
    logic [NUM_BUS*IDX_W-1:0]    cdb_src;
    logic [31:0]                 stall_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit          m_known = 0;
    bit          m_hold_v   [NUM_REQ];
    logic [4:0]  m_hold_tag [NUM_REQ];
    logic [63:0] m_hold_val [NUM_REQ];
    int          m_ptr;
    bit          m_cdb_v    [NUM_BUS];
    logic [4:0]  m_cdb_tag  [NUM_BUS];
    logic [63:0] m_cdb_val  [NUM_BUS];
    int          m_cdb_src  [NUM_BUS];
    logic [31:0] m_stall;
    int          m_gq[$];

`ifdef CDB_STALL_CNT_EN
    localparam logic [31:0] STALL_AFTER_ONE = 32'd1;
`else
    localparam logic [31:0] STALL_AFTER_ONE = 32'd0;
`endif

    cdb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .NUM_BUS (NUM_BUS)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst_n),
        .i_squash      (squash),
        .i_req_valid   (req_valid),
        .i_req_tag     (req_tag),
        .i_req_value   (req_value),
        .o_req_ready   (req_ready),
        .o_cdb_valid   (cdb_valid),
        .o_cdb_tag     (cdb_tag),
        .o_cdb_value   (cdb_value),
        .o_cdb_src     (cdb_src),
        .o_stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Held producers in scan order from the pointer; first NUM_BUS of them win.
    task automatic model_grants();
        m_gq.delete();
        for (int k = 0; k < NUM_REQ; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQ;
            if (m_hold_v[i] && m_gq.size() < NUM_BUS) m_gq.push_back(i);
        end
    endtask

    task automatic model_step(input bit rst, input bit sq, input logic [NUM_REQ-1:0] rv);
        bit granted [NUM_REQ];
        bit any_stall;
        model_grants();
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) m_hold_v[i] = 0;
            for (int b = 0; b < NUM_BUS; b++) begin
                m_cdb_v[b] = 0; m_cdb_tag[b] = '0; m_cdb_val[b] = '0; m_cdb_src[b] = 0;
            end
            m_ptr   = 0;
            m_stall = '0;
            m_known = 1;
            return;
        end
        for (int i = 0; i < NUM_REQ; i++) granted[i] = 0;
        foreach (m_gq[k]) granted[m_gq[k]] = 1;
        any_stall = 0;
        for (int i = 0; i < NUM_REQ; i++) if (m_hold_v[i] && !granted[i]) any_stall = 1;
`ifdef CDB_STALL_CNT_EN
        if (any_stall && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
        for (int b = 0; b < NUM_BUS; b++) begin
            if (!sq && b < m_gq.size()) begin
                m_cdb_v[b]   = 1;
                m_cdb_tag[b] = m_hold_tag[m_gq[b]];
                m_cdb_val[b] = m_hold_val[m_gq[b]];
                m_cdb_src[b] = m_gq[b];
            end else begin
                m_cdb_v[b] = 0; m_cdb_tag[b] = '0; m_cdb_val[b] = '0; m_cdb_src[b] = 0;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            bit rdy;
            rdy = !m_hold_v[i] || granted[i];
            if (rv[i] && rdy) begin
                m_hold_tag[i] = req_tag[i*TAG_W +: TAG_W];
                m_hold_val[i] = req_value[i*DATA_W +: DATA_W];
                m_hold_v[i]   = 1;
            end else if (granted[i]) begin
                m_hold_v[i] = 0;
            end
            if (sq) m_hold_v[i] = 0;
        end
        if (!sq && m_gq.size() > 0) m_ptr = (m_gq[m_gq.size()-1] + 1) % NUM_REQ;
    endtask

    task automatic compare_outputs();
        logic [NUM_REQ-1:0] exp_ready;
        model_grants();
        for (int i = 0; i < NUM_REQ; i++) begin
            exp_ready[i] = !m_hold_v[i];
            foreach (m_gq[k]) if (m_gq[k] == i) exp_ready[i] = 1'b1;
        end
        check("req_ready", req_ready, exp_ready);
        for (int b = 0; b < NUM_BUS; b++) begin
            check($sformatf("cdb_valid[%0d]", b), cdb_valid[b], m_cdb_v[b]);
            check($sformatf("cdb_tag[%0d]", b), cdb_tag[b*TAG_W +: TAG_W], m_cdb_tag[b]);
            check($sformatf("cdb_value[%0d]", b), cdb_value[b*DATA_W +: DATA_W], m_cdb_val[b]);
            check($sformatf("cdb_src[%0d]", b), cdb_src[b*IDX_W +: IDX_W], m_cdb_src[b]);
        end
        check("stall_count", stall_count, m_stall);
    endtask

    // Called at a negedge; returns at the next negedge with post-edge outputs settled.
    task automatic cycle(input bit rst, input bit sq, input logic [NUM_REQ-1:0] rv,
                         input bit rnd = 1);
        rst_n     = rst;
        squash    = sq;
        req_valid = rv;
        if (rnd) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_tag[i*TAG_W +: TAG_W]      = TAG_W'($urandom);
                req_value[i*DATA_W +: DATA_W]  = {$urandom, $urandom};
            end
        end
        #1;
        if (m_known) compare_outputs();
        @(posedge clk);
        model_step(rst, sq, rv);
        @(negedge clk);
    endtask

    task automatic check_srcs(input string tag, input int s0, input int s1);
        check({tag, "_valid"}, cdb_valid, 2'b11);
        check({tag, "_src0"}, cdb_src[0 +: IDX_W], s0);
        check({tag, "_src1"}, cdb_src[IDX_W +: IDX_W], s1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp0[4];
        int exp1[4];
        exp0 = '{0, 2, 4, 1};
        exp1 = '{1, 3, 0, 2};
        rst_n = 1'b0; squash = 1'b0; req_valid = '0; req_tag = '0; req_value = '0;
        @(negedge clk);

        // Reset held two cycles with every producer requesting
        cycle(0, 0, 5'b11111);
        cycle(0, 0, 5'b11111);
        check("rst_cdb_valid", cdb_valid, 2'b00);
        check("rst_ready", req_ready, 5'b11111);
        check("rst_stall", stall_count, 32'd0);

        // Single producer, 2-cycle latency
        req_tag[REQ_MULT1*TAG_W +: TAG_W]      = 5'd7;
        req_value[REQ_MULT1*DATA_W +: DATA_W]  = 64'h1234;
        cycle(1, 0, 5'b00100, 0);
        cycle(1, 0, 5'b00000);
        check("single_valid", cdb_valid, 2'b01);
        check("single_tag", cdb_tag[0 +: TAG_W], 5'd7);
        check("single_value", cdb_value[0 +: DATA_W], 64'h1234);
        check("single_src", cdb_src[0 +: IDX_W], REQ_MULT1);

        // All producers saturated from pointer 0
        cycle(0, 0, 5'b00000);
        cycle(1, 0, 5'b11111);
        for (int p = 0; p < 4; p++) begin
            cycle(1, 0, 5'b11111);
            check_srcs($sformatf("rr%0d", p), exp0[p], exp1[p]);
        end

        // Wrap: holds 4 and 0 with pointer at 4, then pointer must land on 1
        cycle(0, 0, 5'b00000);
        cycle(1, 0, 5'b01100);
        cycle(1, 0, 5'b10001);
        cycle(1, 0, 5'b00000);
        check_srcs("wrap", REQ_MEM, REQ_ALU1);
        cycle(1, 0, 5'b00111);
        cycle(1, 0, 5'b00000);
        check_srcs("ptr1", REQ_ALU2, REQ_MULT1);
        cycle(1, 0, 5'b00000);
        cycle(1, 0, 5'b00000);

        // Squash with 1 and 3 held and a producer-0 capture in the same cycle
        cycle(1, 0, 5'b01010);
        cycle(1, 1, 5'b00001);
        check("sq_cdb_valid", cdb_valid, 2'b00);
        check("sq_ready", req_ready, 5'b11111);
        cycle(1, 0, 5'b00000);
        check("sq_drop0", cdb_valid, 2'b00);
        cycle(1, 0, 5'b00000);
        check("sq_drop1", cdb_valid, 2'b00);
        cycle(1, 0, 5'b00111);
        cycle(1, 0, 5'b00000);
        check_srcs("sq_ptr", REQ_ALU2, REQ_MULT1);
        cycle(1, 0, 5'b00000);
        cycle(1, 0, 5'b00000);

        // Stall statistic: three held, no new input
        cycle(0, 0, 5'b00000);
        check("stall_rst", stall_count, 32'd0);
        cycle(1, 0, 5'b00111);
        for (int c = 0; c < 4; c++) begin
            cycle(1, 0, 5'b00000);
            check($sformatf("stall_c%0d", c), stall_count, STALL_AFTER_ONE);
        end

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            bit r;
            bit s;
            logic [NUM_REQ-1:0] v;
            r = ($urandom % 64) != 0;
            s = ($urandom % 16) == 0;
            v = NUM_REQ'($urandom | $urandom);
            cycle(r, s, v);
        end
        cycle(1, 0, 5'b00000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
